// File: rtl/arith_pkg.sv
// Shared definitions for the sign-magnitude arithmetic datapath
// (add-shift multiplier and add-subtract divider).
package arith_pkg;

    // Default operand width, sign bit included.
    localparam int W     = 8;
    // Magnitude width.
    localparam int M     = W - 1;
    // Iteration counter width.
    localparam int CNT_W = $clog2(M);

    // Iterative-unit control states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Result sign from the two operand signs.
    // A zero magnitude always yields +0, so -0 never leaves the datapath.
    function automatic logic sm_sign(input logic xs, input logic ys, input logic mag_zero);
        return (xs ^ ys) & ~mag_zero;
    endfunction

endpackage

// File: rtl/mul_as.sv
// Sequential sign-magnitude multiplier, iterative add-shift, one
// magnitude bit per clock.
//
// Handshake: start is sampled only while busy=0. The accepting edge
// latches x and y, and busy is high for the next M cycles. The
// completing edge updates p and raises done for exactly one cycle.
// start while busy=1 is dropped (neither queued nor restarting).
// start in the done cycle is accepted, because busy is already low.
module mul_as #(
    parameter int W = arith_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           start,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done,
    output logic           dbg_state
);
    import arith_pkg::*;

    localparam int MAG_W = W - 1;
    localparam int CW    = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAG_W - 1);

    state_e               state_q;
    logic [MAG_W-1:0]     mc_q;
    logic [MAG_W-1:0]     mp_q;
    logic [MAG_W-1:0]     acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sgn_q;
    logic [2*W-1:0]       p_q;
    logic                 busy_q;
    logic                 done_q;

    logic [MAG_W:0]       sum;
    logic [MAG_W:0]       sel;
    logic [MAG_W-1:0]     acc_d;
    logic [MAG_W-1:0]     mp_d;
    logic [2*MAG_W-1:0]   mag_d;
    logic [2*W-1:0]       p_d;

    // One add-shift step: conditionally add the multiplicand, then shift
    // the {carry, acc, mp} pair right by one.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, mc_q};
        sel   = mp_q[0] ? sum : {1'b0, acc_q};
        acc_d = sel[MAG_W:1];
        mp_d  = {sel[0], mp_q[MAG_W-1:1]};
        mag_d = {acc_d, mp_d};
        p_d   = {sm_sign(sgn_q, 1'b0, ~|mag_d), 1'b0, mag_d};
    end

    // Control FSM and datapath registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mc_q    <= x[MAG_W-1:0];
                        mp_q    <= y[MAG_W-1:0];
                        sgn_q   <= x[W-1] ^ y[W-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mp_q  <= mp_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        p_q     <= p_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p         = p_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = (state_q == RUN);

endmodule

// File: doc/mul_as.md
Name: mul_as

Overview:
Sequential sign-magnitude multiplier using iterative add-shift, one magnitude bit per clock. It is the companion of the sign-magnitude add-subtract divider in the arithmetic datapath and uses the same operand format: bit W-1 is the sign, bits W-2:0 are the magnitude. The two blocks form a round trip, so z*y + r from the divider reconstructs the dividend through this block. Start/busy handshake matches the divider, with an added one-cycle done pulse.

Parameters:
W, 8, operand width including sign bit; magnitude width M = W-1; product width 2W.

Ports:
clk    input   1    clock, all logic on rising edge
rst    input   1    synchronous active-high reset
x      input   W    multiplicand, sign-magnitude
y      input   W    multiplier, sign-magnitude
start  input   1    request; sampled only when busy=0
p      output  2W   product, sign-magnitude: p[2W-1]=sign, p[2W-2]=0, p[2W-3:0]=|x|*|y|
busy   output  1    high while iterating
done   output  1    one-cycle pulse when p updates

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: p=0, busy=0, done=0, state=IDLE, counter=0, internal accumulators=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE to RUN, at the edge where start=1 and busy=0 (edge E0):
  - latch mc=x[M-1:0] and mp=y[M-1:0];
  - latch sgn=x[W-1]^y[W-1];
  - acc=0, cnt=0, busy<=1.
- RUN, one iteration per edge:
  - if mp[0], then {acc,mp} <= ({carry, acc+mc, mp}) >> 1; else {acc,mp} <= {acc,mp} >> 1;
  - acc is M bits plus a 1-bit carry;
  - cnt <= cnt+1.
- Final iteration: the edge with cnt==M-1 (edge E0+M) does the last step and also:
  - p <= {sgn_n, 1'b0, acc_next, mp_next};
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: busy is high for exactly M cycles (7 at W=8). done is high for the cycle after edge E0+M, i.e. M cycles after start was sampled.
- Negative zero normalisation: if the 2M-bit magnitude is 0, the product sign is forced to 0 (e.g. -0 * 5 = +0).
- Operands are latched at start. Changes on x and y while busy=1 have no effect.
- start while busy=1 is ignored; it is neither queued nor allowed to restart.
- start in the cycle done=1 is accepted, since busy=0 then. This gives back-to-back operations with one idle cycle between busy periods.
- done is deasserted on every edge except a completing edge.
- p holds its value until the next completion or reset. p does not change at start.
- Reset mid-operation: the operation is abandoned, no done pulse, and p=0.
- Reset takes priority over start on the same edge.
- Widths: the magnitude product never exceeds 2M bits, so there is no overflow. Maximum at W=8 is 127*127 = 16129 = 0x3F01.

Decomposition:
- Shared package arith_pkg:
  - W default;
  - localparams M=W-1 and CNT_W=$clog2(M);
  - state enum {IDLE, RUN};
  - function sm_sign(x,y) returning the sign with zero normalisation, reused by the divider's sign logic.
- No sub-module is needed; the datapath is a single add-shift register pair. An optional separate counter is not warranted.

Test Plan:
- x=0x05, y=0x03, start for one cycle -> busy high 7 cycles, then done for 1 cycle, p=0x000F.
- x=0x85 (-5), y=0x03 -> p=0x800F. x=0x85, y=0x83 (-3) -> p=0x000F.
- x=0x7F, y=0xFF (-127) -> p=0xBF01. x=0x80 (-0), y=0x05 -> p=0x0000, sign normalised.
- Start x=0x02, y=0x03, then on the 3rd busy cycle drive start=1 with x=0x7F, y=0x7F -> ignored, p=0x0006. Start asserted in the done cycle with 0x04 * 0x04 -> accepted, p=0x0010 seven cycles later.
- Start 0x7F * 0x7F, assert rst on the 4th busy cycle -> next cycle busy=0, p=0, and no done pulse ever appears for that operation.
- Round trip with the divider: for all x, and y in 0x01..0x7F, divider(x,y)=(z,r) -> mul_as(z,y) magnitude + |r| == |x|.
